// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - operation encodings presented on op
//   - FSM state type used by the top level
//   - clog2 helper for sizing the iteration counter
// Optional feature macro used elsewhere in the unit: MDU_SIGNED_EN.
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_DIVU  = 2'b01;
    localparam logic [1:0] MDU_MULT  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/multiply_divide_unit_if.sv
// -----------------------------------------------------------------------------
// multiply_divide_unit_if
// Request/result bundle between the datapath and the multiply/divide unit.
//   start, op, a, b      : operation request (captured when start is taken)
//   hi_we, lo_we, wdata  : direct HI/LO writes
//   busy, done           : handshake status
//   div_by_zero          : divide-by-zero flag, valid with done
//   hi, lo               : result registers
// master drives requests, slave (the unit) drives status and results.
// -----------------------------------------------------------------------------
interface multiply_divide_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_iter_datapath.sv
// -----------------------------------------------------------------------------
// mdu_iter_datapath
// Unsigned iterative engine: shift-add multiply or restoring shift-subtract
// divide, one step per cycle, WIDTH steps per operation.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   load_i             : capture operands and preload counter to WIDTH-1
//   is_div_i           : 1 = divide, 0 = multiply (captured with load_i)
//   opa_i, opb_i       : multiplicand/dividend and multiplier/divisor
//   step_i             : perform one iteration
//   last_o             : the current step is the final one (counter at 0)
//   hi_res_o, lo_res_o : product halves, or remainder/quotient
// -----------------------------------------------------------------------------
module mdu_iter_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             step_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_res_o,
    output logic [WIDTH-1:0] lo_res_o
);
    localparam int CW = clog2(WIDTH);

    // acc: running upper product / partial remainder
    // mq : multiplier bits shifting out / quotient bits shifting in
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, mq_q[WIDTH-1]};
        // Extra guard bit keeps the borrow unambiguous for any shift value.
        div_diff  = {1'b0, div_shift} - {2'b00, opd_q};
        div_ge    = ~div_diff[WIDTH+1];

        acc_d    = acc_q;
        mq_d     = mq_q;
        opd_d    = opd_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;

        if (load_i) begin
            acc_d    = '0;
            mq_d     = opa_i;
            opd_d    = opb_i;
            cnt_d    = CW'(WIDTH - 1);
            is_div_d = is_div_i;
        end else if (step_i) begin
            if (is_div_q) begin
                acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                mq_d  = {mq_q[WIDTH-2:0], div_ge};
            end else begin
                acc_d = mul_sum[WIDTH:1];
                mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mq_q     <= '0;
            opd_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opd_q    <= opd_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
        end
    end

    assign last_o   = (cnt_q == '0);
    assign hi_res_o = acc_q;
    assign lo_res_o = mq_q;

endmodule

// File: rtl/multiply_divide_unit.sv
// -----------------------------------------------------------------------------
// multiply_divide_unit
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO result registers and direct
// HI/LO writes. Latency from the accepting edge to results is WIDTH+1 cycles.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (aborts any operation silently)
//   bus   : multiply_divide_unit_if.slave (start/op/a/b, hi_we/lo_we/wdata,
//           busy/done/div_by_zero, hi/lo)
// Optional feature: define MDU_SIGNED_EN to make op 10/11 signed MULT/DIV;
// otherwise op[1] is ignored and all operations are unsigned.
// -----------------------------------------------------------------------------
module multiply_divide_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    multiply_divide_unit_if.slave  bus
);
    mdu_state_e       state_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             is_div_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] a_q;

    logic [WIDTH-1:0] opa_mag;
    logic [WIDTH-1:0] opb_mag;
    logic             dp_load;
    logic             dp_step;
    logic             dp_last;
    logic [WIDTH-1:0] dp_hi;
    logic [WIDTH-1:0] dp_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [2*WIDTH-1:0] prod;

`ifdef MDU_SIGNED_EN
    // Signed operations iterate on magnitudes; signs are reapplied in FIX.
    logic a_neg;
    logic b_neg;
    logic neg_res_q;
    logic neg_rem_q;

    assign a_neg   = bus.op[1] & bus.a[WIDTH-1];
    assign b_neg   = bus.op[1] & bus.b[WIDTH-1];
    assign opa_mag = a_neg ? -bus.a : bus.a;
    assign opb_mag = b_neg ? -bus.b : bus.b;

    assign prod   = neg_res_q ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
    assign div_lo = neg_res_q ? -dp_lo : dp_lo;
    assign div_hi = neg_rem_q ? -dp_hi : dp_hi;
`else
    logic unused_op1;

    assign unused_op1 = bus.op[1];
    assign opa_mag    = bus.a;
    assign opb_mag    = bus.b;

    assign prod   = {dp_hi, dp_lo};
    assign div_lo = dp_lo;
    assign div_hi = dp_hi;
`endif

    // Divide by zero bypasses sign correction entirely.
    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_q && b_zero_q) begin
            res_hi = a_q;
            res_lo = '1;
        end else if (is_div_q) begin
            res_hi = div_hi;
            res_lo = div_lo;
        end
    end

    assign dp_load = (state_q == IDLE) && bus.start;
    assign dp_step = (state_q == RUN);

    mdu_iter_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load_i   (dp_load),
        .is_div_i (bus.op[0]),
        .opa_i    (opa_mag),
        .opb_i    (opb_mag),
        .step_i   (dp_step),
        .last_o   (dp_last),
        .hi_res_o (dp_hi),
        .lo_res_o (dp_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            a_q       <= '0;
`ifdef MDU_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A start takes priority; same-cycle direct writes are dropped.
                    if (bus.start) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        dbz_q     <= 1'b0;
                        is_div_q  <= bus.op[0];
                        b_zero_q  <= (bus.b == '0);
                        a_q       <= bus.a;
`ifdef MDU_SIGNED_EN
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
`endif
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                RUN: begin
                    if (dp_last) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    dbz_q   <= is_div_q & b_zero_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// -----------------------------------------------------------------------------
// tb_multiply_divide_unit
// Directed test of multiply_divide_unit (WIDTH = 32). Expected values for the
// signed operations follow whether MDU_SIGNED_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_multiply_divide_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    multiply_divide_unit_if #(.WIDTH(W)) bus ();

    multiply_divide_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge (E0).
    // Returns at the negedge just after E0.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts negedges from the one just after E0 (index lat0) until done.
    task automatic wait_done(input int lat0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Full transaction; leaves the bench at the negedge of the done cycle.
    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input logic exp_dbz);
        int lat;
        int bcnt;
        launch(op, a, b);
        wait_done(0, lat, bcnt);
        $display("txn %s op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0b lat=%0d",
                 tag, op, a, b, bus.hi, bus.lo, bus.div_by_zero, lat);
        check({tag, "_latency"}, 64'(lat), 64'(33));
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(33));
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        int lat;
        int bcnt;
        int done_seen;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        $display("txn reset busy=%0b done=%0b hi=0x%08h lo=0x%08h", bus.busy, bus.done, bus.hi, bus.lo);
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_done", 64'(bus.done), 64'(0));
        check("reset_dbz", 64'(bus.div_by_zero), 64'(0));
        check("reset_hi", 64'(bus.hi), 64'(0));
        check("reset_lo", 64'(bus.lo), 64'(0));

        // Largest unsigned product.
        do_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'(0));

        // DIVU chain, each start issued in the previous done cycle.
        do_op("divu_7_2", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
        do_op("divu_5_0", MDU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        launch(MDU_DIVU, 32'd100, 32'd7);
        check("dbz_cleared_on_start", 64'(bus.div_by_zero), 64'(0));
        wait_done(0, lat, bcnt);
        $display("txn divu_100_7 b2b -> hi=0x%08h lo=0x%08h lat=%0d", bus.hi, bus.lo, lat);
        check("b2b_latency", 64'(lat), 64'(33));
        check("divu_100_7_hi", 64'(bus.hi), 64'(2));
        check("divu_100_7_lo", 64'(bus.lo), 64'(14));
        @(negedge clk);

        // Signed operations (or their unsigned fallbacks).
`ifdef MDU_SIGNED_EN
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF1;
`else
        exp_hi = 32'h0000_0002; exp_lo = 32'hFFFF_FFF1;
`endif
        do_op("mult_m5_3", MDU_MULT, 32'hFFFF_FFFB, 32'd3, exp_hi, exp_lo, 1'b0);
`ifdef MDU_SIGNED_EN
        exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
`else
        exp_hi = 32'h0000_0001; exp_lo = 32'h7FFF_FFFC;
`endif
        do_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, exp_hi, exp_lo, 1'b0);
`ifdef MDU_SIGNED_EN
        exp_hi = 32'h0000_0000; exp_lo = 32'h8000_0000;
`else
        exp_hi = 32'h8000_0000; exp_lo = 32'h0000_0000;
`endif
        do_op("div_min_m1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, exp_hi, exp_lo, 1'b0);
        do_op("div_m5_0", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);

        // Start and lo_we while busy are both ignored.
        launch(MDU_MULTU, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("lo_stable_in_run", 64'(bus.lo), 64'hFFFF_FFFF);
        wait_done(6, lat, bcnt);
        $display("txn multu_3_4 with ignored start/lo_we -> hi=0x%08h lo=0x%08h lat=%0d", bus.hi, bus.lo, lat);
        check("busy_ignore_latency", 64'(lat), 64'(33));
        check("busy_ignore_hi", 64'(bus.hi), 64'(0));
        check("busy_ignore_lo", 64'(bus.lo), 64'(12));
        @(negedge clk);

        // Reset mid-operation aborts silently.
        launch(MDU_MULTU, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("txn abort busy=%0b hi=0x%08h lo=0x%08h", bus.busy, bus.hi, bus.lo);
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_hi", 64'(bus.hi), 64'(0));
        check("abort_lo", 64'(bus.lo), 64'(0));
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(done_seen), 64'(0));

        // Direct writes.
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.hi_we = 1'b0;
        $display("txn mthi -> hi=0x%08h lo=0x%08h", bus.hi, bus.lo);
        check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        check("mthi_lo_untouched", 64'(bus.lo), 64'(0));
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        $display("txn mthi+mtlo -> hi=0x%08h lo=0x%08h", bus.hi, bus.lo);
        check("both_we_hi", 64'(bus.hi), 64'hA5A5_A5A5);
        check("both_we_lo", 64'(bus.lo), 64'hA5A5_A5A5);

        // start and lo_we together: start wins.
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_0055;
        launch(MDU_MULTU, 32'd2, 32'd3);
        bus.lo_we = 1'b0;
        check("start_wins_lo_held", 64'(bus.lo), 64'hA5A5_A5A5);
        wait_done(0, lat, bcnt);
        $display("txn multu_2_3 with lo_we -> hi=0x%08h lo=0x%08h lat=%0d", bus.hi, bus.lo, lat);
        check("start_wins_latency", 64'(lat), 64'(33));
        check("start_wins_hi", 64'(bus.hi), 64'(0));
        check("start_wins_lo", 64'(bus.lo), 64'(6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiply_divide_unit.md
# multiply_divide_unit

Iterative multi-cycle multiply/divide unit with HI/LO result registers, parametrised in operand width. It is the sequential companion to the single-cycle ALU in the processor datapath. It executes MULT/MULTU/DIV/DIVU under a start/busy/done handshake and holds results in HI/LO for mfhi/mflo-style reads. HI/LO can also be written directly (mthi/mtlo).

## Interface
- WIDTH, 32, operand and HI/LO width; must be at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- a  in  WIDTH  multiplicand / dividend; captured with start.
- b  in  WIDTH  multiplier / divisor; captured with start.
- hi_we  in  1  write wdata into HI; honoured only in IDLE.
- lo_we  in  1  write wdata into LO; honoured only in IDLE.
- wdata  in  WIDTH  direct-write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  valid with done; set when a divide had b==0.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE: start=1 captures a, b, op and loads iteration counter = WIDTH-1; next state RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. At count 0, next state FIX.
  - FIX: applies sign correction, writes HI/LO, pulses done; next state IDLE.
- Multiply: full 2*WIDTH product; HI = upper half, LO = lower half.
- Divide: LO = quotient, HI = remainder.
- Signed ops (with the macro enabled):
  - Iterate on magnitudes.
  - Product is negated when sign(a)^sign(b).
  - Quotient is negated when sign(a)^sign(b); remainder takes the sign of a.
- Signed DIV of most-negative by -1: LO = most-negative, HI = 0, no flag.
- Divide by zero (either mode): same latency; HI = a, LO = all ones, div_by_zero = 1; sign correction is skipped.
- div_by_zero is cleared at the next accepted start or at reset.
- start while busy (RUN/FIX) is ignored; no queueing.
- hi_we/lo_we outside IDLE are ignored.
- start and hi_we/lo_we in the same IDLE cycle: start wins and the writes are dropped.
- hi_we and lo_we together: both registers are written.
- Reset, including mid-operation: state IDLE, busy = 0, done = 0, div_by_zero = 0, hi = 0, lo = 0. The aborted operation never raises done.

## Timing
- Let E0 be the edge that samples start.
- busy = 1 from E0 until edge E0+WIDTH+1.
- At edge E0+WIDTH+1: HI/LO updated, done = 1 for exactly one cycle, busy = 0.
- Latency from E0 to result is WIDTH+1 cycles (33 for WIDTH = 32).
- During the done cycle the unit is in IDLE and accepts a new start back-to-back.
- Direct writes: HI/LO take wdata at the sampling edge, visible the following cycle.
- hi/lo are stable outside the FIX edge and direct writes; intermediate iteration values never appear on hi/lo.

## Configuration
- MDU_SIGNED_EN defined: op 10/11 perform two's-complement MULT/DIV as described above.
- MDU_SIGNED_EN undefined:
  - op[1] is ignored, so MULT behaves as MULTU and DIV as DIVU.
  - Sign-fixup logic is omitted.
  - FIX state remains; latency is unchanged.

## Structure
- Package mdu_pkg contains:
  - op encoding constants (MDU_MULTU, MDU_DIVU, MDU_MULT, MDU_DIV);
  - FSM state typedef (IDLE, RUN, FIX);
  - counter width function clog2(WIDTH).
- Sub-module mdu_iter_datapath holds the shift registers, adder/subtractor and counter, and exposes a step/last interface.
- The top level holds the FSM, HI/LO registers, sign fixup and handshake.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at E0+33; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- DIVU a=7 b=2 -> lo=3, hi=1, div_by_zero=0. Then DIVU a=5 b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1.
- Signed operations:
  - With MDU_SIGNED_EN: MULT -5*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Without MDU_SIGNED_EN: MULT -5*3 -> hi=0x00000002, lo=0xFFFFFFF1.
- Busy and abort behaviour:
  - MULTU 3*4, with start re-asserted with other operands at cycle 5 -> ignored; result hi=0, lo=12.
  - New start at cycle 10, then reset at cycle 10 of it -> busy=0, hi=lo=0, no done pulse.
- Direct writes:
  - hi_we with wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle.
  - lo_we during RUN -> ignored.
  - start and lo_we in the same cycle -> start executes, LO is not written from wdata.
- Back-to-back: start asserted in the done cycle of a DIVU -> accepted; second done exactly 33 cycles later.
